// File: rtl/cpu_pkg.sv
// Shared CPU types for the register-file write path: widths, the write
// request record and a one-hot decode helper for register bitmaps.
package cpu_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;

    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] wn;
        logic [XLEN-1:0]  d;
    } wreq_t;

    function automatic logic [NREG-1:0] reg_bit(input logic [REG_W-1:0] n);
        return NREG'(1) << n;
    endfunction

endpackage

// File: rtl/rf_wfifo.sv
// Small FIFO for MDU results waiting on the register-file write port.
// full/empty are registered so they never depend on same-cycle push/pop.
module rf_wfifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  clrn,
    input  logic  push,
    input  logic  pop,
    input  wreq_t din,
    output wreq_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    wreq_t          mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    cnt, cnt_nxt;
    logic           do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop)
            cnt_nxt = cnt + (AW+1)'(1);
        else if (!do_push && do_pop)
            cnt_nxt = cnt - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == (AW+1)'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

    // Storage needs no reset: entries are only visible through a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: WB has priority, MDU results bypass or
// queue, a starve counter forces a WB hold, and a busy scoreboard drives stall.
module rf_wport_arb
    import cpu_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_wn,
    input  logic [XLEN-1:0]  wb_d,
    output logic             wb_hold,
    input  logic             mdu_valid,
    input  logic [REG_W-1:0] mdu_wn,
    input  logic [XLEN-1:0]  mdu_d,
    output logic             mdu_ready,
    input  logic             iss_we,
    input  logic [REG_W-1:0] iss_wn,
    input  logic [REG_W-1:0] d_rna,
    input  logic [REG_W-1:0] d_rnb,
    input  logic [REG_W-1:0] d_wn,
    input  logic             d_wchk,
    output logic             stall,
    output logic             rf_we,
    output logic [REG_W-1:0] rf_wn,
    output logic [XLEN-1:0]  rf_d
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    wreq_t            head, enq, wr;
    logic             fempty, ffull;
    logic             wbreq, pop, bypass, push, mdu_nz;
    logic             mdu_wr;
    logic [REG_W-1:0] mdu_wr_n;
    logic [NREG-1:0]  busy, busy_nxt, clr_vec, set_vec, live;
    logic [CW-1:0]    starve;

    assign mdu_nz = (mdu_wn != '0);
    assign wbreq  = wb_we && (wb_wn != '0) && !wb_hold;
    assign pop    = !wbreq && !fempty;
    assign bypass = !wbreq && fempty && mdu_valid;

    assign mdu_ready = bypass || !ffull;
    // r0 results are acknowledged but never stored or written.
    assign push      = mdu_valid && mdu_ready && !bypass && mdu_nz;
    assign enq       = '{we: 1'b1, wn: mdu_wn, d: mdu_d};

    rf_wfifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .pop   (pop),
        .din   (enq),
        .dout  (head),
        .full  (ffull),
        .empty (fempty)
    );

    always_comb begin
        wr = '0;
        if (wbreq)
            wr = '{we: 1'b1, wn: wb_wn, d: wb_d};
        else if (pop)
            wr = head;
        else if (bypass && mdu_nz)
            wr = enq;
    end

    assign rf_we = wr.we && clrn;
    assign rf_wn = wr.wn;
    assign rf_d  = wr.d;

    assign mdu_wr   = pop || (bypass && mdu_nz);
    assign mdu_wr_n = pop ? head.wn : mdu_wn;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (mdu_wr)
            clr_vec = reg_bit(mdu_wr_n);
        if (iss_we && (iss_wn != '0))
            set_vec = reg_bit(iss_wn);
    end

    // A register being written back this cycle is readable by the next posedge.
    assign live     = busy & ~clr_vec;
    assign busy_nxt = live | set_vec;
    assign stall    = live[d_rna] | live[d_rnb] | (d_wchk & live[d_wn]);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            starve  <= '0;
            wb_hold <= 1'b0;
        end else begin
            wb_hold <= 1'b0;
            if (ffull && wbreq) begin
                if (starve == CW'(STARVE_MAX - 1)) begin
                    starve  <= '0;
                    wb_hold <= 1'b1;
                end else begin
                    starve <= starve + CW'(1);
                end
            end else begin
                starve <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_rf_wport_arb;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        wb_we = 1'b0, mdu_valid = 1'b0, iss_we = 1'b0, d_wchk = 1'b0;
    logic [4:0]  wb_wn = '0, mdu_wn = '0, iss_wn = '0, d_rna = '0, d_rnb = '0, d_wn = '0;
    logic [31:0] wb_d = '0, mdu_d = '0;
    logic        wb_hold, mdu_ready, stall, rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;

    int nchk = 0;
    int npass = 0;

    rf_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .clrn(clrn),
        .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d), .wb_hold(wb_hold),
        .mdu_valid(mdu_valid), .mdu_wn(mdu_wn), .mdu_d(mdu_d), .mdu_ready(mdu_ready),
        .iss_we(iss_we), .iss_wn(iss_wn),
        .d_rna(d_rna), .d_rnb(d_rnb), .d_wn(d_wn), .d_wchk(d_wchk), .stall(stall),
        .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [4:0] wn; logic [31:0] d; } ent_t;
    ent_t      mq[$];
    bit [31:0] m_busy;
    int        m_cnt;
    bit        m_hold;

    always @(negedge clk or negedge clrn) begin
        bit          full0, wbreq, pop, byp, ready, ewe, mwr, est, nh;
        logic [4:0]  ewn;
        logic [31:0] ed;
        bit [31:0]   live;
        if (!clrn) begin
            mq.delete();
            m_busy = '0;
            m_cnt  = 0;
            m_hold = 1'b0;
        end else begin
            full0 = (mq.size() == DEPTH);
            wbreq = wb_we && (wb_wn != 0) && !m_hold;
            pop   = !wbreq && (mq.size() > 0);
            byp   = !wbreq && (mq.size() == 0) && mdu_valid;
            ewe = 1'b0; ewn = '0; ed = '0;
            if (wbreq) begin
                ewe = 1'b1; ewn = wb_wn; ed = wb_d;
            end else if (pop) begin
                ewe = 1'b1; ewn = mq[0].wn; ed = mq[0].d;
            end else if (byp && mdu_wn != 0) begin
                ewe = 1'b1; ewn = mdu_wn; ed = mdu_d;
            end
            ready = byp || !full0;
            mwr   = ewe && !wbreq;
            live  = m_busy;
            if (mwr) live[ewn] = 1'b0;
            est = live[d_rna] | live[d_rnb] | (d_wchk & live[d_wn]);

            chk("m_rf_we",   32'(rf_we),     32'(ewe));
            chk("m_rf_wn",   32'(rf_wn),     32'(ewn));
            chk("m_rf_d",    rf_d,           ed);
            chk("m_ready",   32'(mdu_ready), 32'(ready));
            chk("m_stall",   32'(stall),     32'(est));
            chk("m_wb_hold", 32'(wb_hold),   32'(m_hold));

            if (pop) void'(mq.pop_front());
            if (mdu_valid && ready && !byp && mdu_wn != 0) mq.push_back('{mdu_wn, mdu_d});
            m_busy = live;
            if (iss_we && iss_wn != 0) m_busy[iss_wn] = 1'b1;
            nh = 1'b0;
            if (full0 && wbreq) begin
                m_cnt++;
                if (m_cnt == STARVE_MAX) begin
                    m_cnt = 0;
                    nh = 1'b1;
                end
            end else begin
                m_cnt = 0;
            end
            m_hold = nh;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        wb_we = 0; wb_wn = 0; wb_d = 0;
        mdu_valid = 0; mdu_wn = 0; mdu_d = 0;
        iss_we = 0; iss_wn = 0;
        d_rna = 0; d_rnb = 0; d_wn = 0; d_wchk = 0;
    endtask

    initial begin
        // 1: reset state and a plain WB write
        #8;
        chk("rst_rf_we",   32'(rf_we),     32'd0);
        chk("rst_ready",   32'(mdu_ready), 32'd1);
        chk("rst_stall",   32'(stall),     32'd0);
        chk("rst_wb_hold", 32'(wb_hold),   32'd0);
        #4 clrn = 1'b1;
        tick(); wb_we = 1; wb_wn = 3; wb_d = 32'h11;
        settle();
        chk("wb_we", 32'(rf_we), 32'd1);
        chk("wb_wn", 32'(rf_wn), 32'd3);
        chk("wb_d",  rf_d,       32'h11);

        // 2: bypass clears a busy register with no stall
        tick(); idle(); iss_we = 1; iss_wn = 5;
        tick(); idle(); mdu_valid = 1; mdu_wn = 5; mdu_d = 32'hABCD; d_rna = 5;
        settle();
        chk("byp_wn",    32'(rf_wn),     32'd5);
        chk("byp_d",     rf_d,           32'hABCD);
        chk("byp_ready", 32'(mdu_ready), 32'd1);
        chk("byp_stall", 32'(stall),     32'd0);
        tick(); idle(); d_rna = 5;
        settle();
        chk("byp_busy_clr", 32'(stall), 32'd0);

        // 3: contention fills the FIFO, drain is in order
        tick(); idle(); wb_we = 1; wb_wn = 1; wb_d = 32'h100;
        mdu_valid = 1; mdu_wn = 6; mdu_d = 32'h66;
        tick(); mdu_wn = 7; mdu_d = 32'h77;
        tick(); mdu_valid = 0;
        settle();
        chk("ord_full_ready", 32'(mdu_ready), 32'd0);
        chk("ord_wb_wn",      32'(rf_wn),     32'd1);
        tick(); wb_we = 0;
        settle();
        chk("ord_first",  32'(rf_wn),     32'd6);
        chk("ord_first_d", rf_d,          32'h66);
        chk("ord_ready0", 32'(mdu_ready), 32'd0);
        tick();
        settle();
        chk("ord_second", 32'(rf_wn),     32'd7);
        chk("ord_ready1", 32'(mdu_ready), 32'd1);
        tick();
        settle();
        chk("ord_empty_we", 32'(rf_we), 32'd0);

        // 4: starvation forces one WB hold after STARVE_MAX full cycles
        tick(); idle(); wb_we = 1; wb_wn = 2; wb_d = 32'h22;
        mdu_valid = 1; mdu_wn = 6; mdu_d = 32'h606;
        tick(); mdu_wn = 7; mdu_d = 32'h707;
        for (int c = 1; c <= STARVE_MAX + 1; c++) begin
            tick(); mdu_valid = 0;
            settle();
            chk($sformatf("starve_hold_c%0d", c), 32'(wb_hold), (c == STARVE_MAX + 1) ? 32'd1 : 32'd0);
        end
        chk("starve_head_wn", 32'(rf_wn), 32'd6);
        tick();
        settle();
        chk("starve_after_hold", 32'(wb_hold), 32'd0);
        chk("starve_wb_back",    32'(rf_wn),   32'd2);
        tick(); wb_we = 0;
        settle();
        chk("starve_drain", 32'(rf_wn), 32'd7);

        // 5: scoreboard hazards
        tick(); idle(); iss_we = 1; iss_wn = 9;
        tick(); idle(); d_rnb = 9;
        settle();
        chk("sb_raw", 32'(stall), 32'd1);
        tick(); idle(); d_wn = 9; d_wchk = 1;
        settle();
        chk("sb_waw", 32'(stall), 32'd1);
        tick(); idle(); d_wn = 9; d_wchk = 0;
        settle();
        chk("sb_waw_off", 32'(stall), 32'd0);
        tick(); idle(); d_rna = 0;
        settle();
        chk("sb_r0", 32'(stall), 32'd0);
        tick(); idle(); iss_we = 1; iss_wn = 9; mdu_valid = 1; mdu_wn = 9; mdu_d = 32'h99;
        tick(); idle(); d_rna = 9;
        settle();
        chk("sb_set_wins", 32'(stall), 32'd1);
        tick(); idle(); mdu_valid = 1; mdu_wn = 9; mdu_d = 32'h999; d_rna = 9;
        tick(); idle(); d_rna = 9;
        settle();
        chk("sb_cleared", 32'(stall), 32'd0);

        // 6: asynchronous reset with a full FIFO and a busy register
        tick(); idle(); wb_we = 1; wb_wn = 1; iss_we = 1; iss_wn = 4;
        mdu_valid = 1; mdu_wn = 6; mdu_d = 32'h6;
        tick(); iss_we = 0; mdu_wn = 7; mdu_d = 32'h7;
        tick(); mdu_valid = 0;
        @(posedge clk); #3;
        clrn = 1'b0;
        #1;
        chk("arst_rf_we", 32'(rf_we), 32'd0);
        idle();
        @(posedge clk); #3;
        clrn = 1'b1;
        tick(); idle(); d_rna = 4;
        settle();
        chk("arst_no_stale", 32'(rf_we),     32'd0);
        chk("arst_ready",    32'(mdu_ready), 32'd1);
        chk("arst_busy",     32'(stall),     32'd0);
        tick(); idle();
        settle();
        chk("arst_no_stale2", 32'(rf_we), 32'd0);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            int pwb;
            pwb = ((i / 500) % 3 == 0) ? 90 : (((i / 500) % 3 == 1) ? 50 : 20);
            tick();
            wb_we     = ($urandom_range(0, 99) < pwb);
            wb_wn     = 5'($urandom_range(0, 31));
            wb_d      = $urandom;
            mdu_valid = ($urandom_range(0, 99) < 60);
            mdu_wn    = 5'($urandom_range(0, 15));
            mdu_d     = $urandom;
            iss_we    = ($urandom_range(0, 99) < 30);
            iss_wn    = 5'($urandom_range(0, 15));
            d_rna     = 5'($urandom_range(0, 15));
            d_rnb     = 5'($urandom_range(0, 15));
            d_wn      = 5'($urandom_range(0, 15));
            d_wchk    = 1'($urandom_range(0, 1));
        end
        tick(); idle();
        settle();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
